// File: rtl/mont_r2_precompute.sv
// Computes R^2 mod m (R = 2^K_BITS) for an odd modulus by 2*K_BITS modular doublings of 1.
// Start/done handshake matches the Montgomery multiplier so one controller can drive both.
module mont_r2_precompute #(
    parameter int K_BITS = 256
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_Start,
    input  logic [K_BITS-1:0] i_m,
    output logic [K_BITS-1:0] o_R2,
    output logic              o_Err,
    output logic              o_Done
);

    localparam int CNT_W = $clog2(2 * K_BITS) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * K_BITS - 1);
    localparam logic [K_BITS-1:0] M_ONE = {{(K_BITS - 1){1'b0}}, 1'b1};

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_INIT    = 2'd1;
    localparam logic [1:0] ST_COMPUTE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    logic [1:0]        state_q,   state_d;
    logic [CNT_W-1:0]  counter_q, counter_d;
    logic [K_BITS-1:0] x_q,       x_d;
    logic [K_BITS-1:0] m_reg_q,   m_reg_d;
    logic [K_BITS-1:0] r2_q,      r2_d;
    logic              err_q,     err_d;

    logic              dbl_ge_m;
    logic [K_BITS-1:0] x_shl;
    logic [K_BITS-1:0] x_red;

    // Because x < m, 2x < 2m and a single conditional subtract reduces it.
    // The wide compare uses x's top bit; the subtract can then run at K_BITS
    // since the true difference is below m and fits.
    always_comb begin
        dbl_ge_m = {x_q, 1'b0} >= {1'b0, m_reg_q};
        x_shl    = {x_q[K_BITS-2:0], 1'b0};
        x_red    = dbl_ge_m ? (x_shl - m_reg_q) : x_shl;
    end

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        x_d       = x_q;
        m_reg_d   = m_reg_q;
        r2_d      = r2_q;
        err_d     = err_q;

        case (state_q)
            ST_IDLE: begin
                if (i_Start) begin
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                m_reg_d   = i_m;
                x_d       = M_ONE;
                counter_d = '0;
                if (!i_m[0] || (i_m == M_ONE)) begin
                    r2_d    = '0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    err_d   = 1'b0;
                    state_d = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                x_d = x_red;
                if (counter_q == CNT_LAST) begin
                    r2_d    = x_red;
                    state_d = ST_DONE;
                end else begin
                    counter_d = counter_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (!i_Start) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q   <= ST_IDLE;
            counter_q <= '0;
            x_q       <= '0;
            m_reg_q   <= '0;
            r2_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            x_q       <= x_d;
            m_reg_q   <= m_reg_d;
            r2_q      <= r2_d;
            err_q     <= err_d;
        end
    end

    assign o_R2   = r2_q;
    assign o_Err  = err_q;
    assign o_Done = (state_q == ST_DONE);

endmodule

// File: tb/tb_mont_r2_precompute.sv
// Self-checking bench for mont_r2_precompute: an 8-bit instance for directed cases and a
// 256-bit instance for random odd moduli, with expected results queued on a scoreboard.
module tb_mont_r2_precompute;

   localparam int KS = 8;
   localparam int KL = 256;

   logic clk = 1'b0;
   logic rst;
   logic start8;
   logic [KS-1:0] m8;
   logic [KS-1:0] r2_8;
   logic err8;
   logic done8;
   logic start256;
   logic [KL-1:0] m256;
   logic [KL-1:0] r2_256;
   logic err256;
   logic done256;

   typedef struct {
      logic [255:0] r2;
      logic         err;
      int           lat;
   } exp_t;

   exp_t sbQ[$];
   int checks = 0;
   int errors = 0;
   logic [255:0] lastR2;
   logic [255:0] lastObs;

   mont_r2_precompute #(.K_BITS(KS)) dut8 (
      .i_Clk(clk), .i_Rst(rst), .i_Start(start8), .i_m(m8),
      .o_R2(r2_8), .o_Err(err8), .o_Done(done8)
   );

   mont_r2_precompute #(.K_BITS(KL)) dut256 (
      .i_Clk(clk), .i_Rst(rst), .i_Start(start256), .i_m(m256),
      .o_R2(r2_256), .o_Err(err256), .o_Done(done256)
   );

   always #5 clk = ~clk;

   // Every comparison in the bench is funnelled through here so counts stay honest
   task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [255:0] getR2(input bit big);
      return big ? r2_256 : {248'd0, r2_8};
   endfunction

   function automatic logic getDone(input bit big);
      return big ? done256 : done8;
   endfunction

   function automatic logic getErr(input bit big);
      return big ? err256 : err8;
   endfunction

   // Reference: 2^(2k) mod m computed directly with wide division
   function automatic logic [255:0] modelR2(input logic [255:0] m, input int k);
      logic [767:0] pow;
      logic [767:0] rem;
      pow = 768'd1 << (2 * k);
      rem = pow % {512'd0, m};
      return rem[255:0];
   endfunction

   task automatic stepEdge();
      @(posedge clk);
      #1;
   endtask

   // Queue the model's answer, then raise start on the chosen instance
   task automatic applyStimulus(input bit big, input logic [255:0] m);
      exp_t e;
      int k;
      k = big ? KL : KS;
      if (!m[0] || m == 256'd1) begin
         e.r2  = '0;
         e.err = 1'b1;
         e.lat = 2;
      end else begin
         e.r2  = modelR2(m, k);
         e.err = 1'b0;
         e.lat = 2 * k + 2;
      end
      sbQ.push_back(e);
      if (big) begin
         m256 = m;
         start256 = 1'b1;
      end else begin
         m8 = m[KS-1:0];
         start8 = 1'b1;
      end
   endtask

   // Count edges until done, checking the old result stays put; chgAt>0 scrambles i_m then
   task automatic waitResult(input bit big, input string tag, input int chgAt);
      exp_t e;
      int edges;
      int bound;
      edges = 0;
      bound = (big ? 2 * KL : 2 * KS) + 22;
      while (edges < bound) begin
         stepEdge();
         edges++;
         if (getDone(big)) break;
         checkOutput({tag, "_held"}, getR2(big), lastR2);
         if (edges == chgAt) begin
            if (big) m256 = '1;
            else m8 = '1;
         end
      end
      if (sbQ.size() == 0) begin
         checkOutput({tag, "_sb_empty"}, 256'd1, 256'd0);
      end else begin
         e = sbQ.pop_front();
         checkOutput({tag, "_lat"}, 256'(edges), 256'(e.lat));
         checkOutput({tag, "_r2"}, getR2(big), e.r2);
         checkOutput({tag, "_err"}, {255'd0, getErr(big)}, {255'd0, e.err});
         lastR2  = e.r2;
         lastObs = getR2(big);
      end
   endtask

   task automatic releaseStart(input bit big, input string tag);
      if (big) start256 = 1'b0;
      else start8 = 1'b0;
      stepEdge();
      checkOutput({tag, "_idle"}, {255'd0, getDone(big)}, 256'd0);
   endtask

   task automatic runOne(input bit big, input logic [255:0] m, input string tag);
      applyStimulus(big, m);
      waitResult(big, tag, 0);
      releaseStart(big, tag);
   endtask

   initial begin
      logic [255:0] rm;
      logic [767:0] modW;
      logic [767:0] fiveR;
      logic [767:0] lhs;
      logic [767:0] rhs;

      rst = 1'b1;
      start8 = 1'b0;
      start256 = 1'b0;
      m8 = '0;
      m256 = '0;
      lastR2 = '0;
      lastObs = '0;
      repeat (3) stepEdge();
      checkOutput("rst_r2_8", getR2(0), 256'd0);
      checkOutput("rst_err_8", {255'd0, err8}, 256'd0);
      checkOutput("rst_done_8", {255'd0, done8}, 256'd0);
      checkOutput("rst_r2_256", getR2(1), 256'd0);
      checkOutput("rst_done_256", {255'd0, done256}, 256'd0);
      rst = 1'b0;
      stepEdge();

      $display("[TB] basic run m=13");
      runOne(0, 256'd13, "m13");

      $display("[TB] back-to-back m=251 then m=255");
      runOne(0, 256'd251, "m251");
      runOne(0, 256'd255, "m255");

      $display("[TB] invalid moduli then recovery");
      runOne(0, 256'd12, "m12");
      runOne(0, 256'd1, "m1");
      runOne(0, 256'd13, "m13b");

      $display("[TB] reset during compute");
      m8 = 8'd13;
      start8 = 1'b1;
      repeat (7) stepEdge();
      checkOutput("pre_rst_done", {255'd0, done8}, 256'd0);
      checkOutput("pre_rst_r2", getR2(0), lastR2);
      rst = 1'b1;
      #1;
      checkOutput("midrst_done", {255'd0, done8}, 256'd0);
      checkOutput("midrst_r2", getR2(0), 256'd0);
      checkOutput("midrst_err", {255'd0, err8}, 256'd0);
      start8 = 1'b0;
      stepEdge();
      rst = 1'b0;
      lastR2 = '0;
      stepEdge();
      checkOutput("post_rst_done", {255'd0, done8}, 256'd0);
      runOne(0, 256'd13, "m13_rst");

      $display("[TB] modulus change after capture, start held");
      applyStimulus(0, 256'd13);
      waitResult(0, "chg", 2);
      for (int i = 0; i < 40; i++) begin
         stepEdge();
         checkOutput("hold_done", {255'd0, done8}, 256'd1);
         checkOutput("hold_r2", getR2(0), 256'd3);
      end
      releaseStart(0, "chg");
      m8 = 8'd0;

      $display("[TB] random 8-bit odd moduli");
      for (int i = 0; i < 6; i++) begin
         rm = 256'($urandom_range(3, 255) | 1);
         runOne(0, rm, "rnd8");
      end

      $display("[TB] random 256-bit moduli");
      lastR2 = '0;
      for (int i = 0; i < 50; i++) begin
         for (int w = 0; w < 8; w++) rm[w*32 +: 32] = $urandom();
         rm[255] = 1'b1;
         rm[0] = 1'b1;
         applyStimulus(1, rm);
         waitResult(1, "rnd256", 0);
         // MMM(5, R2) = 5*R2/R must equal 5R mod m, i.e. 5*R2 == (5R mod m)*R mod m
         modW  = {512'd0, rm};
         fiveR = (768'd5 << 256) % modW;
         lhs   = ({512'd0, lastObs} * 768'd5) % modW;
         rhs   = (fiveR << 256) % modW;
         checkOutput("mmm_5R", lhs[255:0], rhs[255:0]);
         releaseStart(1, "rnd256");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mont_r2_precompute.md
Name: mont_r2_precompute

Overview:
- Computes the Montgomery conversion constant R^2 mod m, with R = 2^K_BITS, for an odd modulus m.
- Sits directly upstream of the Montgomery multiplier. The multiplier uses its output as the B operand to bring operands into the Montgomery domain: MMM(A, R^2) = A*R mod m.
- Uses iterative shift-and-conditional-subtract: one modular doubling per cycle, 2*K_BITS cycles in total.
- Uses the same level-sensitive start/done handshake as the multiplier, so a controller can drive both blocks identically.

Parameters:
K_BITS, 256, operand/modulus width; R = 2^K_BITS.

Ports:
i_Clk     input   1       clock, rising edge.
i_Rst     input   1       reset, asynchronous, active-high.
i_Start   input   1       level request; sampled in IDLE.
i_m       input   K_BITS  modulus; captured in INIT.
o_R2      output  K_BITS  R^2 mod m; registered.
o_Err     output  1       modulus invalid (even, or equal to 1); registered.
o_Done    output  1       high while in DONE.

Behaviour:
- Reset state: i_Rst=1 asynchronously forces IDLE; counter=0, x=0, m_reg=0, o_R2=0, o_Err=0, o_Done=0.
- States: IDLE, INIT, COMPUTE, DONE.
- IDLE: if i_Start=1, go to INIT. Otherwise stay.
- INIT (1 cycle):
  - m_reg <= i_m; x <= 1; counter <= 0.
  - If i_m[0]=0 or i_m==1: o_R2 <= 0, o_Err <= 1, go to DONE.
  - Otherwise: o_Err <= 0, go to COMPUTE.
- COMPUTE (exactly 2*K_BITS cycles, counter 0 .. 2*K_BITS-1):
  - d = {x,1'b0}, K_BITS+1 bits wide.
  - x <= (d >= m_reg) ? d - m_reg : d, truncated to K_BITS.
  - Invariant: x < m_reg, so one subtraction is sufficient.
  - When counter == 2*K_BITS-1: o_R2 <= the reduced value from this iteration, go to DONE. Otherwise counter <= counter+1.
- DONE:
  - o_Done=1; o_R2 and o_Err are held.
  - Go to IDLE when i_Start=0. If i_Start stays high, remain in DONE (no auto-restart).
- Latency: i_Start seen high in IDLE at edge n → INIT in cycle n+1 → COMPUTE in cycles n+2 .. n+2K+1 → o_Done=1 from cycle n+2K+2.
- Error path: o_Done=1 from cycle n+2.
- o_R2 changes only on the final COMPUTE edge or on the error INIT edge.
  - Intermediate x is never visible at the output.
  - The previous result persists through IDLE/INIT/COMPUTE of the next run.
- i_m changes after INIT have no effect on the current run.
- Counter width: $clog2(2*K_BITS)+1 bits. The terminal compare must not wrap.
- Reset asserted mid-COMPUTE: immediate return to IDLE, outputs cleared, no partial result. A new i_Start after reset release starts a full run.
- i_Start dropping during INIT/COMPUTE is ignored; the run completes and passes through DONE for at least one cycle.
- Comparison d >= m_reg is unsigned, full K_BITS+1 width.

Test Plan:
1. K_BITS=8, m=13 (0x0D), pulse i_Start high until done -> o_Done at cycle n+18, o_R2=3 (65536 mod 13), o_Err=0.
2. K_BITS=8, m=251 -> o_R2=25; m=255 -> o_R2=1; run back-to-back, dropping i_Start for one cycle between runs -> each o_R2 valid while o_Done=1, previous value held during the second run.
3. K_BITS=8, m=12 and m=1 -> o_Done at cycle n+2, o_Err=1, o_R2=0. Then m=13 -> o_Err clears to 0, o_R2=3.
4. K_BITS=8, m=13; assert i_Rst at COMPUTE counter=5 -> o_Done, o_R2, o_Err immediately 0, state IDLE. Restart -> o_R2=3 after the full 18-cycle latency.
5. K_BITS=8, change i_m to 0xFF on the cycle after INIT; hold i_Start high for 40 cycles -> result 3 (m=13 used), o_Done stays high, no second run until i_Start=0.
6. K_BITS=256, 50 random odd moduli with MSB set -> o_R2 equals the reference model 2^512 mod m. Then chain o_R2 into the multiplier with A=5 -> the multiplier returns 5*2^256 mod m.
